// File: rtl/lzc_iter_if.sv
// Handshake bundle for lzc_iter: operand channel (in_*) and result channel (out_*).
// Both channels use valid/ready: a transfer happens on a rising clock edge where
// valid and ready are both 1; the producer holds valid and payload stable until
// that edge, and ready never depends combinationally on valid.
interface lzc_iter_if #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic             out_zero;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_count, out_zero
    );

    // The counting block.
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_count, out_zero
    );
endinterface

// File: rtl/lzc_iter.sv
// Iterative leading-zero / leading-one counter. Scans the operand CHUNK bits per
// cycle from the MSB; leading-one mode inverts the operand at capture so both
// modes share the same zero scan. One operand in flight at a time.
module lzc_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    lzc_iter_if.slave   bus,
    output logic [1:0]  fsm_state
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    count;
    logic             out_valid_q;
    logic [CW-1:0]    out_count_q;
    logic             out_zero_q;

    logic [CHUNK-1:0] top_chunk;
    logic [CW-1:0]    chunk_lz;
    logic             found;

    assign top_chunk     = work[WIDTH-1 -: CHUNK];
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_count = out_count_q;
    assign bus.out_zero  = out_zero_q;
    assign fsm_state     = state;

    // Leading zeros inside the top chunk; only used when the chunk is non-zero.
    always_comb begin
        chunk_lz = CW'(CHUNK);
        found    = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (!found && top_chunk[i]) begin
                chunk_lz = CW'(CHUNK - 1 - i);
                found    = 1'b1;
            end
        end
    end

    // Control FSM plus datapath: capture, chunk-by-chunk scan, result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            work        <= '0;
            idx         <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work  <= bus.in_mode ? ~bus.in_data : bus.in_data;
                        count <= '0;
                        idx   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (top_chunk != '0) begin
                        // A non-zero chunk means the total stays below WIDTH.
                        out_count_q <= count + chunk_lz;
                        out_zero_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else if (idx == IW'(NCHUNK - 1)) begin
                        out_count_q <= CW'(WIDTH);
                        out_zero_q  <= 1'b1;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        count <= count + CW'(CHUNK);
                        work  <= work << CHUNK;
                        idx   <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/lzc_iter.md
LZC_ITER -- requirements
Module: lzc_iter

Interface
REQ-001 Parameter WIDTH, default 32: operand width; SHALL be a multiple of CHUNK and at least 8.
REQ-002 Parameter CHUNK, default 8: bits examined per scan cycle; SHALL be a power of two, 4..WIDTH.
REQ-003 Derived CW = clog2(WIDTH+1): count width.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 in_valid  input  1: operand offered.
REQ-007 in_ready  output  1: block can accept an operand.
REQ-008 in_data  input  WIDTH: operand; MSB is bit WIDTH-1.
REQ-009 in_mode  input  1: 0 = count leading zeros; 1 = count leading ones.
REQ-010 out_valid  output  1: result available.
REQ-011 out_ready  input  1: consumer takes the result.
REQ-012 out_count  output  CW: leading-zero count or leading-one count, range 0..WIDTH.
REQ-013 out_zero  output  1: every bit equals the counted value (out_count == WIDTH).

Function
REQ-014 Accept on a rising edge where in_valid and in_ready are both 1; in_data and in_mode are captured at that edge.
REQ-015 Captured operand SHALL be bitwise inverted when in_mode = 1, so both modes reduce to a leading-zero scan.
REQ-016 FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready = 1; on accept -> SCAN, with count = 0 and chunk index = 0.
- SCAN: in_ready = 0; each cycle examines the top CHUNK bits of the working register.
- DONE: out_valid = 1; on out_ready = 1 -> IDLE.
REQ-017 SCAN, top chunk non-zero: count += leading zeros within that chunk -> DONE.
REQ-018 SCAN, top chunk zero and not the last chunk: count += CHUNK; working register shifts left by CHUNK; chunk index increments; stay in SCAN.
REQ-019 SCAN, top chunk zero and it is the last chunk (index WIDTH/CHUNK-1): count = WIDTH -> DONE.
REQ-020 Latency: accept at edge t. The first non-zero chunk is k-th from the MSB, with k = WIDTH/CHUNK if the operand is all zero. out_valid SHALL rise at edge t+k. Minimum latency is 1; maximum is WIDTH/CHUNK.
REQ-021 out_count and out_zero SHALL be registered. They SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-022 out_zero = 1 exactly when out_count == WIDTH.
REQ-023 No overlap: in_ready = 0 in SCAN and DONE, and in_valid is ignored there. in_ready SHALL NOT combinationally depend on out_ready. The earliest next accept is the edge after the DONE-to-IDLE edge.
REQ-024 out_valid SHALL be 0 in IDLE and SCAN.
REQ-025 Count arithmetic is CW bits wide and SHALL never wrap; the maximum value is WIDTH.
REQ-026 in_data and in_mode may change freely after the accept without affecting the result.

Reset
REQ-027 Reset is sampled on a rising edge with rst = 1. On such an edge: state = IDLE, out_valid = 0, out_count = 0, out_zero = 0, and the working register and chunk index are cleared.
REQ-028 Reset SHALL take priority over accept, scan and handshake in the same cycle.
REQ-029 Reset mid-SCAN or mid-DONE SHALL abort the operation with no result emitted. in_ready = 1 in the first cycle after rst deasserts.

Verification (WIDTH=32, CHUNK=8)
REQ-030 in_data = 0x8000_0000, mode 0, accept at t -> out_valid at t+1, out_count = 0, out_zero = 0.
REQ-031 in_data = 0x0000_0001, mode 0 -> out_valid at t+4, out_count = 31.
REQ-032 in_data = 0x0000_0000, mode 0 -> out_valid at t+4, out_count = 32, out_zero = 1. Same result for in_data = 0xFFFF_FFFF with mode 1.
REQ-033 in_data = 0xFFFF_F0FF, mode 1 -> out_valid at t+3, out_count = 20.
REQ-034 Backpressure: hold out_ready = 0 for 5 cycles in DONE while in_valid = 1 with new data.
- Required: out_valid, out_count and out_zero stay stable and in_ready stays 0.
- After out_ready = 1: exactly one transfer, then IDLE with in_ready = 1.
REQ-035 Reset abort: assert rst for one cycle at t+2 during a scan of 0x0000_0001.
- Required: out_valid stays 0 and the block returns to IDLE.
- A following operand 0x00F0_0000 yields out_count = 8.
